// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package ifetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;

  typedef logic [DEF_ADDR_W-1:0] pc_t;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    pc_t                    pc;
  } fetch_entry_t;

  // Word-align a PC by clearing the byte-offset bits.
  function automatic pc_t align_pc(input pc_t pc);
    return pc & ~pc_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO holding fetched {instr, pc} entries.
// Storage is not reset; only pointers and occupancy are.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; written on push only.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  // The credit scheme upstream must never let a push meet a full queue.
  assert property (@(posedge clock) disable iff (!reset)
                   (push && !flush) |-> (count != CNT_W'(DEPTH)));

endmodule

// File: rtl/ifetch_queue.sv
// Pipelined instruction fetch: PC generation, credit-limited requests to a
// variable-latency in-order memory, a prefetch queue toward decode, and
// redirect handling that flushes queued and in-flight fetches.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_target,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [INSTR_W-1:0]         dec_instr,
  output logic [ADDR_W-1:0]          dec_pc,
  output logic [ADDR_W-1:0]          dec_pc_plus_4,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int                CNT_W   = $clog2(DEPTH + 1);
  localparam int                SUM_W   = CNT_W + 1;
  localparam logic [SUM_W-1:0]  CREDITS = SUM_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  // Word-align an incoming target; the low byte-offset bits are ignored.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(INSTR_BYTES - 1);
  endfunction

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic              credit_ok;
  logic              issue;
  logic              resp_drop;
  logic              push;
  logic              pop;
  entry_t            push_data;
  entry_t            head;

  // Queued plus in-flight entries may never exceed the queue depth, so every
  // response that is kept is guaranteed a free slot.
  assign credit_ok = ({1'b0, q_count} + {1'b0, outstanding}) < CREDITS;
  assign imem_req  = reset & ~redirect_valid & credit_ok;
  assign imem_addr = fetch_pc;
  assign issue     = imem_req & imem_gnt;

  // Responses belonging to a squashed fetch stream are discarded.
  assign resp_drop = imem_rvalid & (drop_cnt != '0);
  assign push      = reset & imem_rvalid & ~redirect_valid & (drop_cnt == '0);
  assign push_data = '{instr: imem_rdata, pc: resp_pc};

  assign dec_valid     = reset & ~redirect_valid & (q_count != '0);
  assign pop           = dec_valid & dec_ready;
  assign dec_instr     = head.instr;
  assign dec_pc        = head.pc;
  assign dec_pc_plus_4 = head.pc + PC_STEP;

  // PC, credit and drop bookkeeping; a redirect overrides everything else.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= word_align(redirect_target);
      resp_pc     <= word_align(redirect_target);
      outstanding <= outstanding - CNT_W'(imem_rvalid);
      drop_cnt    <= outstanding - CNT_W'(imem_rvalid);
    end else begin
      if (issue) fetch_pc <= fetch_pc + PC_STEP;
      if (push)  resp_pc  <= resp_pc + PC_STEP;
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(imem_rvalid);
      if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  ifetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (q_count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order fixed-latency memory and a
// queue-based reference model checked every cycle.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             redirect_valid;
  logic [31:0]      redirect_target;
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_instr;
  logic [31:0]      dec_pc;
  logic [31:0]      dec_pc_plus_4;
  logic [CNT_W-1:0] q_count;

  always #5 clock = ~clock;

  ifetch_queue #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_pc_plus_4   (dec_pc_plus_4),
    .q_count         (q_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: queued PCs, fetch/response PCs, credit counts.
  logic [31:0] m_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_resp_pc;
  int          m_out;
  int          m_drop;
  bit          m_init = 1'b0;

  // Memory model: granted addresses with the cycle their response is due.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    lat = 1;

  // Values sampled in the most recent cycle.
  logic             s_req;
  logic [31:0]      s_addr;
  logic             s_dvalid;
  logic [31:0]      s_dpc;
  logic [31:0]      s_dpc4;
  logic [CNT_W-1:0] s_qc;
  bit               s_hs;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: present memory response, compare outputs against the
  // model, advance the model, then move past the next rising edge.
  task automatic step();
    bit          rv;
    logic [31:0] raddr;
    bit          e_req;
    bit          e_dv;
    rv    = 1'b0;
    raddr = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv    = 1'b1;
      raddr = mem_q[0].addr;
      mem_q.delete(0);
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? instr_of(raddr) : 32'h0BAD_0BAD;
    #1;
    e_req = reset && !redirect_valid && ((m_q.size() + m_out) < DEPTH);
    e_dv  = reset && !redirect_valid && (m_q.size() != 0);
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_dvalid = dec_valid;
    s_dpc    = dec_pc;
    s_dpc4   = dec_pc_plus_4;
    s_qc     = q_count;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("dec_valid", 32'(dec_valid), 32'(e_dv));
    if (e_req) chk("imem_addr", imem_addr, m_fetch_pc);
    if (e_dv) begin
      chk("dec_pc", dec_pc, m_q[0]);
      chk("dec_instr", dec_instr, instr_of(m_q[0]));
      chk("dec_pc_plus_4", dec_pc_plus_4, m_q[0] + 32'd4);
    end
    if (m_init) chk("q_count", 32'(q_count), 32'(m_q.size()));
    s_hs = e_dv && dec_ready;
    if (!reset) begin
      m_q.delete();
      mem_q.delete();
      m_fetch_pc = 32'h0;
      m_resp_pc  = 32'h0;
      m_out      = 0;
      m_drop     = 0;
      m_init     = 1'b1;
    end else if (redirect_valid) begin
      m_q.delete();
      m_fetch_pc = {redirect_target[31:2], 2'b00};
      m_resp_pc  = {redirect_target[31:2], 2'b00};
      m_drop     = m_out - int'(rv);
      m_out      = m_out - int'(rv);
    end else begin
      if (e_req && imem_gnt) begin
        mem_q.push_back('{addr: m_fetch_pc, due: cyc + lat});
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_out++;
      end
      if (e_dv && dec_ready) m_q.delete(0);
      if (rv) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin
          m_q.push_back(m_resp_pc);
          m_resp_pc = m_resp_pc + 32'd4;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_iss;
    bit  found;
    reset           = 1'b0;
    imem_gnt        = 1'b1;
    dec_ready       = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;

    // Reset behaviour.
    step();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_dvalid", 32'(s_dvalid), 32'd0);
    step();
    chk("rst_qcount", 32'(s_qc), 32'd0);
    reset = 1'b1;

    // Streaming with 1-cycle memory.
    step(); chk("t1_addr0", s_addr, 32'h0);
    step(); chk("t1_addr1", s_addr, 32'h4);
    step();
    chk("t1_addr2", s_addr, 32'h8);
    chk("t1_dvalid2", 32'(s_dvalid), 32'd1);
    chk("t1_dpc2", s_dpc, 32'h0);
    chk("t1_dpc4_2", s_dpc4, 32'h4);
    step(); chk("t1_dpc3", s_dpc, 32'h4);
    repeat (8) begin
      step();
      chk("t1_throughput", 32'(s_hs), 32'd1);
    end

    // Decode stalled: credits cap requests at DEPTH.
    reset_pulse();
    dec_ready = 1'b0;
    n_iss = 0;
    repeat (10) begin
      step();
      if (s_req && imem_gnt) n_iss++;
    end
    chk("t2_issued", 32'(n_iss), 32'd4);
    chk("t2_qcount", 32'(s_qc), 32'd4);
    chk("t2_req", 32'(s_req), 32'd0);
    dec_ready = 1'b1;
    step(); chk("t2_resume0", s_dpc, 32'h0);
    step(); chk("t2_resume1", s_dpc, 32'h4);
    repeat (6) step();

    // Redirect with two requests in flight on a 3-cycle memory.
    reset_pulse();
    lat = 3;
    step();
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    step();
    chk("t3_redir_req", 32'(s_req), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("t3_req", 32'(s_req), 32'd1);
    chk("t3_addr", s_addr, 32'h0000_0100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_dvalid) found = 1'b1;
    end
    chk("t3_dvalid_seen", 32'(found), 32'd1);
    chk("t3_first_dpc", s_dpc, 32'h0000_0100);
    repeat (4) step();

    // Redirect colliding with a response and a pending pop, then back-to-back.
    reset_pulse();
    lat = 1;
    repeat (5) step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    step();
    chk("t4_no_handshake", 32'(s_dvalid), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("t4_qcount0", 32'(s_qc), 32'd0);
    chk("t4_addr", s_addr, 32'h0000_0200);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    step();
    redirect_target = 32'h0000_0402;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t4_last_wins", s_addr, 32'h0000_0400);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_dvalid) found = 1'b1;
    end
    chk("t4_dvalid_seen", 32'(found), 32'd1);
    chk("t4_first_dpc", s_dpc, 32'h0000_0400);
    repeat (3) step();

    // Address wrap at the top of the address space.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step(); chk("t5_addr0", s_addr, 32'hFFFF_FFF8);
    step(); chk("t5_addr1", s_addr, 32'hFFFF_FFFC);
    step(); chk("t5_addr_wrap", s_addr, 32'h0000_0000);
    chk("t5_dpc0", s_dpc, 32'hFFFF_FFF8);
    step();
    chk("t5_dpc1", s_dpc, 32'hFFFF_FFFC);
    chk("t5_dpc4_wrap", s_dpc4, 32'h0000_0000);
    repeat (3) step();

    // Reset while 3 entries are queued and 1 request is in flight.
    reset_pulse();
    dec_ready = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    step();
    chk("t6_qc_before", 32'(s_qc), 32'd3);
    chk("t6_rst_dvalid", 32'(s_dvalid), 32'd0);
    chk("t6_rst_req", 32'(s_req), 32'd0);
    reset = 1'b1;
    step();
    chk("t6_qc_after", 32'(s_qc), 32'd0);
    chk("t6_dvalid_after", 32'(s_dvalid), 32'd0);
    chk("t6_req_after", 32'(s_req), 32'd1);
    chk("t6_addr_after", s_addr, 32'h0000_0000);
    dec_ready = 1'b1;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
